// File: rtl/pipe_hazard_ctrl.sv
// Hazard and pipeline-enable controller for the 5-stage CPU.
// It produces the operand-forwarding selects and detects load-use hazards.
// It flushes IF/ID on a taken branch and freezes the whole pipeline while a
// data-memory access is outstanding. Memory accesses that never complete
// are abandoned after WAIT_MAX frozen cycles and raise a sticky mem_err.
module pipe_hazard_ctrl #(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             exe_wreg,
    input  logic             exe_m2reg,
    input  logic [4:0]       exe_rn,
    input  logic             mem_wreg,
    input  logic             mem_m2reg,
    input  logic [4:0]       mem_rn,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_exe_bubble,
    output logic             exe_mem_en,
    output logic             mem_wb_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             mem_err
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    // Last wait_cnt value before the access is declared timed out.
    localparam logic [15:0] WAIT_LAST = 16'(WAIT_MAX - 1);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] wait_cnt;
    logic [15:0] wait_cnt_nxt;
    logic        err_set;

    logic        lu;
    logic        frz_run;
    logic        mem_done;
    logic        freeze;

    // Forwarding select for one operand; EXE wins over MEM, r0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] x,
        input logic       e_wreg,
        input logic       e_m2reg,
        input logic [4:0] e_rn,
        input logic       m_wreg,
        input logic       m_m2reg,
        input logic [4:0] m_rn
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (e_wreg && !e_m2reg && (e_rn != 5'd0) && (e_rn == x))
            sel = 2'b01;
        else if (m_wreg && (m_rn != 5'd0) && (m_rn == x))
            sel = m_m2reg ? 2'b11 : 2'b10;
        return sel;
    endfunction

    // Saturating increment for the stall counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Hazard terms: load-use on EXE load, memory stall in RUN and completion.
    always_comb begin
        lu = exe_wreg && exe_m2reg && (exe_rn != 5'd0) &&
             ((id_use_rs && (exe_rn == id_rs)) || (id_use_rt && (exe_rn == id_rt)));
        frz_run  = mem_req && !mem_ready;
        mem_done = mem_req && mem_ready;
        freeze   = (state == RUN) ? frz_run : !mem_done;
    end

    // State register, wait counter and sticky error; reset aborts any wait.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state    <= RUN;
            wait_cnt <= 16'd0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (err_set)
                mem_err <= 1'b1;
        end
    end

    // Next state: enter MEM_WAIT on an unfinished access, leave on completion or timeout.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        err_set      = 1'b0;
        case (state)
            RUN: begin
                if (frz_run) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = 16'd1;
                end else begin
                    wait_cnt_nxt = 16'd0;
                end
            end
            MEM_WAIT: begin
                if (mem_done) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = 16'd0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = 16'd0;
                    err_set      = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + 16'd1;
                end
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = 16'd0;
            end
        endcase
    end

    // Pipeline enables and bubbles: freeze over load-use over branch; all idle in reset.
    always_comb begin
        fwd_a         = 2'b00;
        fwd_b         = 2'b00;
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        if_id_flush   = 1'b0;
        id_exe_bubble = 1'b1;
        exe_mem_en    = 1'b0;
        mem_wb_bubble = 1'b1;
        if (clrn) begin
            fwd_a = fwd_sel(id_rs, exe_wreg, exe_m2reg, exe_rn, mem_wreg, mem_m2reg, mem_rn);
            fwd_b = fwd_sel(id_rt, exe_wreg, exe_m2reg, exe_rn, mem_wreg, mem_m2reg, mem_rn);
            if (freeze) begin
                // ID/EXE holds because both pc_en and id_exe_bubble are low.
                id_exe_bubble = 1'b0;
                mem_wb_bubble = 1'b1;
            end else if (lu) begin
                id_exe_bubble = 1'b1;
                exe_mem_en    = 1'b1;
                mem_wb_bubble = 1'b0;
            end else begin
                pc_en         = 1'b1;
                if_id_en      = 1'b1;
                id_exe_bubble = 1'b0;
                exe_mem_en    = 1'b1;
                mem_wb_bubble = 1'b0;
                if_id_flush   = branch_taken;
            end
        end
    end

    // Count every cycle the PC is held (load-use or freeze), saturating.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            stall_cnt <= '0;
        else if (!pc_en)
            stall_cnt <= sat_inc(stall_cnt);
    end

endmodule
